// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and data access (port 1); one outstanding transaction, bounded wait with abort.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_sel,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state | meaning
  // IDLE  | no transaction; arbitrate on any request
  // BUSY  | owner holds the memory port, waiting for mem_ready or timeout
  // DONE  | one-cycle ack/err/rdata presentation, no arbitration

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;
  logic          win;

  // On a tie the port that did not finish last wins.
  assign win = (req0 && req1) ? ~last : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_sel   <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            mem_sel   <= win;
            gnt0      <= ~win;
            gnt1      <= win;
            mem_addr  <= win ? addr1 : addr0;
            mem_wdata <= win ? wdata1 : wdata0;
            mem_we    <= win ? we1 : we0;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (mem_sel) begin
              ack1   <= 1'b1;
              rdata1 <= mem_we ? '0 : mem_rdata;
            end else begin
              ack0   <= 1'b1;
              rdata0 <= mem_we ? '0 : mem_rdata;
            end
            last    <= mem_sel;
            mem_req <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            if (mem_sel) begin
              ack1 <= 1'b1;
              err1 <= 1'b1;
            end else begin
              ack0 <= 1'b1;
              err0 <= 1'b1;
            end
            last    <= mem_sel;
            mem_req <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single memory port between instruction fetch (port 0) and data access (port 1). It runs a round-robin req/ack handshake with each requester and drives the shared port's address, write-data and write-enable signals. It also drives the select line of the 2:1 muxes that steer those signals. It sits between the fetch/memory stages and the memory, and it enforces one outstanding transaction with a bounded wait.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in BUSY without mem_ready before abort (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0, req1  in  1  per-port request; held high until that port's ack
- addr0, addr1  in  ADDR_W  per-port address; stable while req high
- wdata0, wdata1  in  DATA_W  per-port write data
- we0, we1  in  1  per-port write enable (1 = write)
- gnt0, gnt1  out  1  one-hot; owner of the port during BUSY
- ack0, ack1  out  1  one-cycle completion pulse
- err0, err1  out  1  high with ack when the transaction timed out
- rdata0, rdata1  out  DATA_W  read result; valid in the ack cycle
- mem_sel  out  1  mux select: 0 = port 0, 1 = port 1; drives the shared 2:1 muxes
- mem_req  out  1  memory request, high for the whole of BUSY
- mem_addr  out  ADDR_W  registered address of the owner
- mem_wdata  out  DATA_W  registered write data of the owner
- mem_we  out  1  registered write enable of the owner
- mem_ready  in  1  memory completes the transaction this cycle
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready
- busy  out  1  high in BUSY and DONE

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Internal registers: last (reset 1), wait counter cnt (width clog2(TIMEOUT+1), reset 0).
- IDLE, with no request: stay in IDLE; mem_sel holds its last value.
- IDLE, with any request, at the clock edge:
  - Winner selection: if only one port requests, that port wins. If both request, the winner is the port that is not last.
  - Register mem_sel = winner and gnt = one-hot(winner).
  - Capture the winner's addr, wdata and we into the mem_* registers.
  - Set mem_req = 1, clear cnt, go to BUSY.
- BUSY: mem_* outputs and mem_sel stay frozen; requester inputs are ignored.
- BUSY with mem_ready = 1, at the edge:
  - ack of the owner = 1 and err = 0.
  - rdata of the owner = mem_rdata for a read, 0 for a write.
  - last = owner; mem_req = 0; gnt cleared; go to DONE.
- BUSY with mem_ready = 0 and cnt == TIMEOUT-1, at the edge:
  - ack = 1 and err = 1; rdata = 0.
  - last = owner; mem_req = 0; go to DONE.
- BUSY with mem_ready = 0 otherwise: cnt increments.
- DONE lasts exactly one cycle. ack/err/rdata are visible during it; no arbitration happens; next state is IDLE.
- Outside the ack cycle, ack, err and rdata read 0.
- Handshake rule: if a requester's req is still high in the cycle after DONE, it counts as a new request.
- mem_ready seen outside BUSY is ignored.
- The non-owner's req may rise or fall at any time without affecting the current transaction.
- Reset mid-transaction clears everything at once (mem_req drops asynchronously). No ack is issued; the requester must re-request.

## Timing
- All outputs are registered.
- Reset values: every output is 0; internal last = 1, so port 0 wins the first tie.
- Cycle sequence, where req is sampled in IDLE cycle N:
  - Cycle N+1: BUSY begins; mem_req, gnt and mem_sel are valid.
  - Cycle M ≥ N+1: mem_ready is sampled high.
  - Cycle M+1: DONE; ack is high.
  - Cycle M+2: IDLE; earliest next arbitration edge is at the end of M+2.
- Minimum round-trip with zero-wait memory: req at N → ack at N+2. Back-to-back grants are 3 cycles apart.
- Timeout: with mem_ready never asserted, ack+err appears in cycle N+1+TIMEOUT.
- mem_sel changes only on an IDLE→BUSY edge, so it is glitch-free for the mux.

## Test plan
- Reset check: pulse rst_n low for 3 cycles → all outputs 0, state IDLE.
- Single read: req0 = 1, addr0 = 0x40, memory returns 0xDEADBEEF one cycle after mem_req → mem_sel = 0, mem_addr = 0x40, ack0 = 1 with rdata0 = 0xDEADBEEF two cycles after req; req1 side stays idle.
- Simultaneous requests after reset: req0 = req1 = 1 held for four zero-wait transactions → grant order 0, 1, 0, 1; mem_sel toggles; ack spacing is 3 cycles.
- Write: req1 = 1, we1 = 1, addr1 = 0x100, wdata1 = 0x55; mem_ready delayed 4 cycles → mem_we = 1 and mem_wdata = 0x55 stable for all 5 BUSY cycles; ack1 = 1 with rdata1 = 0.
- Timeout with TIMEOUT = 8 and mem_ready held at 0 → ack0 = err0 = 1 exactly 9 cycles after the grant edge; the next tie goes to port 1.
- Reset mid-BUSY, two cycles into a transaction → mem_req, gnt and busy drop immediately with no ack. After release, a pending req1 is granted first (last = 1 restored, tie → port 0 only if req0 is also high).
